binary_neuron_accum: RTL
========================

# binary_neuron_accum

Parametrised, pipelined binary-weight neuron. Each cycle it accepts one beat of LANES signed activations with one weight bit per lane. It reduces each beat through a registered adder tree and accumulates beats until the last one. It then adds a bias, saturates to DATA_W, and presents the neuron result on a valid/ready output. It sits between the activation buffer and the layer output writer, replacing the fixed 16-lane, single-beat combinational multiply/add tree.

## Interface
- LANES, 16, activations per beat; power of two, 2..64
- DATA_W, 8, signed activation and output width
- ACC_W, 20, signed accumulator width; must be ≥ DATA_W+1+clog2(LANES)
- MAX_BEATS, 64, beat limit per neuron; forced termination at this count
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  beat valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_last  input  1  final beat of the neuron
- input_neuron  input  LANES×DATA_W  signed activations, packed [LANES-1:0][DATA_W-1:0]
- weight_bits  input  LANES  1 → +x, 0 → −x
- bias  input  ACC_W  signed; sampled on the first accepted beat of a neuron
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_data  output  DATA_W  signed saturated result
- out_sat  output  1  out_data was clamped
- acc_ovf  output  1  accumulator saturated at ACC_W, or MAX_BEATS forced termination; meaning is qualified by out_valid

## Operation
- Lane product: DATA_W+1 bits, sign-extended, then negated if weight bit is 0. −2^(DATA_W−1) negates to +2^(DATA_W−1) exactly; no wrap.
- Tree: clog2(LANES) registered levels. Each level widens by 1 bit. It is non-stallable; every accepted beat exits after the same latency.
- Accumulator: saturating signed add at ACC_W. On saturation it clamps to the ACC_W max/min and sets a sticky ovf flag for this neuron.
- Final: bias is added at ACC_W with saturation. The result is clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; out_sat=1 if clamped.
- Beat counter: counts accepted beats. The beat that reaches MAX_BEATS is treated as last even if in_last=0, and acc_ovf=1 for that result.
- FSM states:
  - IDLE: in_ready=1. First accepted beat: capture bias, clear accumulator and ovf; go to ACCUM, or DRAIN if last.
  - ACCUM: in_ready=1. Accepted last beat → DRAIN.
  - DRAIN: in_ready=0. When the last beat leaves the tree, write the final result → HOLD.
  - HOLD: out_valid=1, outputs stable. On out_ready → IDLE.
- in_valid low inside ACCUM: bubbles are ignored and the accumulator holds.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, out_data=0, out_sat=0, acc_ovf=0. Tree and accumulator are cleared.
- Latency: out_valid rises clog2(LANES)+2 rising edges after the edge that accepts the last beat (6 for LANES=16).
  - 1 edge: product register.
  - clog2(LANES) edges: tree.
  - 1 edge: accumulate, bias, saturate into the output register.
- in_ready falls the cycle after the last beat is accepted. It rises the cycle after the out_valid && out_ready handshake. Throughput is one neuron per (beats + latency + 1) cycles.
- Single-beat neuron: first and last in the same beat; bias is captured and the neuron completes normally.
- rst asserted in any state clears everything immediately. In-flight beats are discarded and no result is emitted.

## Configuration
- BNN_RELU_EN defined: a negative final result outputs 0, with out_sat=0. Positive clamping is unchanged.
- BNN_RELU_EN undefined: signed output with symmetric saturation.

## Structure
- bnn_pkg holds:
  - state enum (IDLE, ACCUM, DRAIN, HOLD)
  - tree_depth function (clog2)
  - sat_signed function (value, from-width, to-width → clamped value, sat flag)
- Sub-module binary_adder_tree: parametrised by LANES and IN_W. Registered levels, valid bit and last bit travel alongside the data, output width IN_W+clog2(LANES).

## Test plan
All scenarios use defaults (LANES=16, DATA_W=8, ACC_W=20).
1. One beat, all inputs 1, weights 16'hFFFF, bias 0, last → out_data=16, out_sat=0, out_valid exactly 6 edges after acceptance.
2. One beat, all inputs 10, weights 16'h00FF, bias 5 → out_data=5.
3. Four beats, all inputs 127, all weights 1, bias 0 → sum 8128 → out_data=127, out_sat=1, acc_ovf=0.
4. Lane 0 = −128 with weight 0, other lanes 0, bias −1 → out_data=127, out_sat=0. Negation boundary: no wrap.
5. out_ready held low 10 cycles in HOLD → out_data stable, in_ready=0. Release → in_ready=1 the next cycle. A 64-beat stream without in_last → acc_ovf=1.
6. rst pulsed during DRAIN → out_valid never asserts, in_ready=1, next neuron correct. With BNN_RELU_EN, all inputs 5 with weights 0 → out_data=0.

Source files
------------

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared types and helpers for the binary-weight neuron.
//   state_e    - neuron control states
//   sat_t      - clamped value plus a flag that is set when clamping happened
//   tree_depth - number of adder-tree levels (ceil log2)
//   sat_signed - clamp a signed value to a narrower signed width
package bnn_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StHold} state_e;

  typedef struct packed {
    logic signed [63:0] val;
    logic               sat;
  } sat_t;

  function automatic int unsigned tree_depth(input int unsigned n);
    int unsigned d;
    d = 0;
    for (int unsigned p = 1; p < n; p = p << 1) d++;
    return d;
  endfunction

  // Treats the low from_w bits of value as signed, then clamps to to_w bits.
  function automatic sat_t sat_signed(input logic signed [63:0] value,
                                      input int unsigned from_w,
                                      input int unsigned to_w);
    logic signed [63:0] v, hi, lo;
    sat_t r;
    v = (value <<< (64 - from_w)) >>> (64 - from_w);
    hi = (64'sd1 <<< (to_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (to_w - 1));
    r.val = v;
    r.sat = 1'b0;
    if (v > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (v < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/binary_adder_tree.sv
// binary_adder_tree: fully registered, non-stallable signed reduction tree.
//   clk, rst            - clock, asynchronous active-low reset
//   in_valid, in_last   - beat flags, carried alongside the data
//   in_data             - LANES signed operands of IN_W bits
//   out_valid, out_last - flags delayed by the tree depth
//   out_sum             - signed sum, IN_W + clog2(LANES) bits
// Nodes use heap numbering: node i adds children 2i and 2i+1, node 1 is the
// root, indices >= LANES are the (unregistered) leaves.
module binary_adder_tree
  import bnn_pkg::*;
#(
  parameter int unsigned LANES = 16,
  parameter int unsigned IN_W  = 9,
  localparam int unsigned DEPTH = tree_depth(LANES),
  localparam int unsigned OUT_W = IN_W + DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic [LANES-1:0][IN_W-1:0]   in_data,
  output logic                         out_valid,
  output logic                         out_last,
  output logic signed [OUT_W-1:0]      out_sum
);

  logic signed [OUT_W-1:0] leaf  [LANES];
  logic signed [OUT_W-1:0] sum_q [1:LANES-1];
  logic [DEPTH-1:0]        vld_q, lst_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      leaf[i] = OUT_W'($signed(in_data[i]));
    end
  end

  for (genvar i = 1; i < LANES; i++) begin : g_node
    logic signed [OUT_W-1:0] a, b;
    if (2 * i >= LANES) begin : g_leaf
      assign a = leaf[2*i-LANES];
      assign b = leaf[2*i+1-LANES];
    end else begin : g_inner
      assign a = sum_q[2*i];
      assign b = sum_q[2*i+1];
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) sum_q[i] <= '0;
      else      sum_q[i] <= a + b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q <= DEPTH'({vld_q, in_valid});
      lst_q <= DEPTH'({lst_q, in_last});
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_last  = lst_q[DEPTH-1];
  assign out_sum   = sum_q[1];

endmodule

// File: rtl/binary_neuron_accum.sv
// binary_neuron_accum: pipelined binary-weight neuron with beat accumulation.
//   clk, rst                    - clock, asynchronous active-low reset
//   in_valid/in_ready/in_last   - beat handshake; in_last marks the final beat
//   input_neuron, weight_bits   - LANES signed activations, 1 = +x, 0 = -x
//   bias                        - sampled on the first accepted beat
//   out_valid/out_ready         - result handshake, result held until taken
//   out_data, out_sat, acc_ovf  - saturated result, clamp flag, overflow flag
// Optional build macro: BNN_RELU_EN clamps negative results to zero.
// Pipeline: product register, clog2(LANES) tree levels, accumulate register,
// then bias/saturate into the output register.
module binary_neuron_accum
  import bnn_pkg::*;
#(
  parameter int unsigned LANES     = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ACC_W     = 20,
  parameter int unsigned MAX_BEATS = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [LANES-1:0][DATA_W-1:0] input_neuron,
  input  logic [LANES-1:0]            weight_bits,
  input  logic [ACC_W-1:0]            bias,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_sat,
  output logic                        acc_ovf
);

  localparam int unsigned PROD_W = DATA_W + 1;
  localparam int unsigned SUM_W  = PROD_W + tree_depth(LANES);
  localparam int unsigned CNT_W  = $clog2(MAX_BEATS + 1);

  state_e state_q, state_d;

  logic             accept, first, hit, last_eff;
  logic [CNT_W-1:0] cnt_q, cnt_next;

  assign accept   = in_valid & in_ready;
  assign first    = accept & (state_q == StIdle);
  assign cnt_next = (state_q == StIdle) ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign hit      = (cnt_next == CNT_W'(MAX_BEATS));
  assign last_eff = in_last | hit;

  // Per-neuron bookkeeping captured at beat acceptance.
  logic signed [ACC_W-1:0] bias_q;
  logic                    force_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      bias_q  <= '0;
      force_q <= 1'b0;
    end else if (accept) begin
      cnt_q   <= cnt_next;
      force_q <= (first ? 1'b0 : force_q) | (hit & ~in_last);
      if (first) bias_q <= $signed(bias);
    end
  end

  // Product stage: the 9-bit width makes -(-128) land on +128 without wrap.
  logic [LANES-1:0][PROD_W-1:0] prod_d, prod_q;
  logic                         prod_vld_q, prod_last_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = PROD_W'($signed(input_neuron[i]));
      if (!weight_bits[i]) prod_d[i] = -prod_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      prod_last_q <= 1'b0;
    end else begin
      prod_vld_q  <= accept;
      prod_last_q <= accept & last_eff;
      if (accept) prod_q <= prod_d;
    end
  end

  logic                    tree_vld, tree_last;
  logic signed [SUM_W-1:0] tree_sum;

  binary_adder_tree #(
    .LANES (LANES),
    .IN_W  (PROD_W)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (prod_vld_q),
    .in_last   (prod_last_q),
    .in_data   (prod_q),
    .out_valid (tree_vld),
    .out_last  (tree_last),
    .out_sum   (tree_sum)
  );

  // Accumulate stage; fin_q flags that the final beat has been folded in.
  logic signed [ACC_W-1:0] acc_q;
  logic                    ovf_q, fin_q;
  sat_t                    acc_sat, fin_sat, res_sat;
  logic                    unused_sat;

  always_comb begin
    acc_sat = sat_signed(64'(acc_q) + 64'(tree_sum), ACC_W + 1, ACC_W);
    fin_sat = sat_signed(64'(acc_q) + 64'(bias_q), ACC_W + 1, ACC_W);
    res_sat = sat_signed(fin_sat.val, ACC_W, DATA_W);
`ifdef BNN_RELU_EN
    if (res_sat.val < 0) begin
      res_sat.val = '0;
      res_sat.sat = 1'b0;
    end
`endif
  end

  assign unused_sat = ^{acc_sat.val[63:ACC_W], fin_sat.sat, res_sat.val[63:DATA_W]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      fin_q <= 1'b0;
    end else begin
      fin_q <= tree_vld & tree_last;
      if (first) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else if (tree_vld) begin
        acc_q <= ACC_W'(acc_sat.val);
        ovf_q <= ovf_q | acc_sat.sat;
      end
    end
  end

  // Output register, loaded only once per neuron so it is stable in StHold.
  logic [DATA_W-1:0] out_data_q;
  logic              out_sat_q, acc_ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      acc_ovf_q  <= 1'b0;
    end else if (fin_q) begin
      out_data_q <= DATA_W'(res_sat.val);
      out_sat_q  <= res_sat.sat;
      acc_ovf_q  <= ovf_q | force_q;
    end
  end

  assign out_data = out_data_q;
  assign out_sat  = out_sat_q;
  assign acc_ovf  = acc_ovf_q;

  // Control FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = last_eff ? StDrain : StAccum;
      StAccum: if (accept && last_eff) state_d = StDrain;
      StDrain: if (fin_q) state_d = StHold;
      StHold:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle) || (state_q == StAccum);
    out_valid = (state_q == StHold);
  end

endmodule
